// File: rtl/ask4_pkg.sv
// Shared types and constants for the 4-ASK symbol decision block.
// Level/threshold constants describe the default amplitude; the top re-derives them from LEVEL_A.
package ask4_pkg;

  typedef logic [1:0] sym_t;

  localparam int unsigned OSR            = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 16;

  localparam logic signed [17:0] LEVEL_A_DEF = 18'sd32768;

  localparam logic signed [18:0] THR_POS = 19'sd65536;
  localparam logic signed [18:0] THR_NEG = -19'sd65536;

  localparam logic signed [18:0] LVL_M3 = -19'sd98304;
  localparam logic signed [18:0] LVL_M1 = -19'sd32768;
  localparam logic signed [18:0] LVL_P1 = 19'sd32768;
  localparam logic signed [18:0] LVL_P3 = 19'sd98304;

  localparam sym_t SYM_M3 = 2'b00;
  localparam sym_t SYM_M1 = 2'b01;
  localparam sym_t SYM_P1 = 2'b10;
  localparam sym_t SYM_P3 = 2'b11;

  // Reconstructed amplitude for a decided symbol, given unit amplitude a.
  function automatic logic signed [18:0] level_of(input sym_t s, input logic signed [18:0] a);
    logic signed [18:0] lvl;
    case (s)
      SYM_M3:  lvl = -(a + (a <<< 1));
      SYM_M1:  lvl = -a;
      SYM_P1:  lvl = a;
      default: lvl = a + (a <<< 1);
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/ask4_decision_ref_sym_fifo.sv
// Synchronous FIFO holding transmitted reference symbols awaiting comparison.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module ref_sym_fifo
  import ask4_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] wr_data,
  output logic [1:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  sym_t          mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // When full, the write slot equals the head slot; the head is read before it is overwritten.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ask4_decision.sv
// 4-ASK hard-decision slicer with decision error output and reference-symbol error counting.
// One sample per symbol is sliced on the programmed phase; decisions are compared to a reference FIFO.
module ask4_decision
  import ask4_pkg::*;
#(
  parameter logic signed [17:0] LEVEL_A    = LEVEL_A_DEF,
  parameter int unsigned        FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] x_in,
  input  logic [1:0]  sam_phase,
  input  logic [1:0]  ref_sym,
  input  logic        ref_valid,
  input  logic        clr_cnt,
  output logic [1:0]  sym,
  output logic        sym_valid,
  output logic [17:0] dec_err,
  output logic [15:0] sym_cnt,
  output logic [15:0] err_cnt,
  output logic        ovf,
  output logic        udf
);

  localparam logic signed [18:0] A19 = {LEVEL_A[17], LEVEL_A};
  localparam logic signed [18:0] THR = A19 <<< 1;

  logic [1:0]         phase;
  logic               strobe;
  logic signed [18:0] x_ext;
  sym_t               slice;
  logic signed [18:0] diff;
  logic [17:0]        err_sat;

  sym_t               head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               compare;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase <= '0;
    else       phase <= phase + 2'd1;
  end

  assign strobe = (phase == sam_phase);
  assign x_ext  = {x_in[17], x_in};

  always_comb begin
    slice = SYM_M3;
    if (x_ext >= THR)             slice = SYM_P3;
    else if (x_ext >= 19'sd0)     slice = SYM_P1;
    else if (x_ext >= -THR)       slice = SYM_M1;
  end

  assign diff = x_ext - level_of(slice, A19);

  // 19-bit difference overflows the 18-bit output when its top two bits disagree.
  always_comb begin
    err_sat = diff[17:0];
    if (diff[18] != diff[17]) err_sat = diff[18] ? 18'h20000 : 18'h1FFFF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym       <= '0;
      dec_err   <= '0;
      sym_valid <= 1'b0;
    end else begin
      sym_valid <= strobe;
      if (strobe) begin
        sym     <= slice;
        dec_err <= err_sat;
      end
    end
  end

  assign pop     = sym_valid && !fifo_empty;
  assign compare = pop;

  ref_sym_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (ref_valid),
    .pop     (pop),
    .wr_data (ref_sym),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_cnt <= '0;
      err_cnt <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else if (clr_cnt) begin
      sym_cnt <= '0;
      err_cnt <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      if (compare) begin
        if (sym_cnt != '1) sym_cnt <= sym_cnt + 16'd1;
        if ((head != sym) && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
      end
      if (ref_valid && fifo_full && !pop) ovf <= 1'b1;
      if (sym_valid && fifo_empty)        udf <= 1'b1;
    end
  end

endmodule
